// File: rtl/bcd_serial_addsub.sv
// ============================================================================
// Module   : bcd_serial_addsub
// Brief    : Digit-serial packed-BCD adder/subtractor, LSD first, with
//            start/busy/done handshake, registered result and digit check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   o,
  output logic                  cout,
  output logic                  err
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_RUN    = 1'b1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic            bad_q, bad_d;
  logic            done_q, done_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    o_q, o_d;

  logic       accept;
  logic       running;
  logic       last;
  logic       in_bad;
  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [3:0] bc;
  logic [4:0] z;
  logic       k;
  logic [3:0] sum_dig;

  assign accept  = (state_q == S_IDLE) && start;
  assign running = (state_q == S_RUN);
  assign last    = (idx_q == LAST_IDX);

  // Validity of the operands as presented at capture time.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
        in_bad = 1'b1;
      end
    end
  end

  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // Nine's complement of b for subtraction; carry-in of 1 completes ten's complement.
  always_comb begin
    bc      = sub_q ? (4'd9 - b_dig) : b_dig;
    z       = {1'b0, a_dig} + {1'b0, bc} + {4'd0, carry_q};
    k       = z[4] | (z[3] & z[2]) | (z[3] & z[1]);
    sum_dig = z[3:0] + (k ? 4'd6 : 4'd0);
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_RUN);
    done = done_q;
    o    = o_q;
    cout = cout_q;
    err  = err_q;
  end

  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    bad_d   = bad_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    o_d     = o_q;
    cout_d  = cout_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (accept) begin
      a_d     = a;
      b_d     = b;
      sub_d   = sub;
      carry_d = sub;
      idx_d   = '0;
      acc_d   = '0;
      bad_d   = in_bad;
    end else if (running) begin
      carry_d = k;
      idx_d   = last ? '0 : idx_q + 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IDXW'(i)) begin
          acc_d[4*i +: 4] = sum_dig;
        end
      end
      // Results are published only here so o/cout/err never show partial sums.
      if (last) begin
        o_d    = acc_d;
        cout_d = k;
        err_d  = bad_q;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      bad_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      o_q     <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      bad_q   <= bad_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      o_q     <= o_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Parametrised N-digit packed-BCD adder/subtractor that processes one digit per clock, least significant digit first.
- Uses the team's existing arithmetic: nine's-complement subtraction with carry-in equal to `sub`, and +6 decimal correction.
- Adds a start/busy/done handshake, a registered result and detection of invalid digits.
- Sits between the operand registers and the BCD display/accumulator path; replaces the fixed 2-digit combinational adder where area matters more than latency.

Parameters:
- DIGITS, 4, number of BCD digits per operand; must be ≥ 1.
- IDXW, $clog2(DIGITS) (minimum 1), width of the internal digit index. This is derived and must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- sub  input  1  0 = a+b, 1 = a-b; captured with start.
- a  input  4*DIGITS  packed BCD operand; digit i is a[4i+3:4i].
- b  input  4*DIGITS  packed BCD operand, same layout.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; o, cout and err are valid from this cycle on.
- o  output  4*DIGITS  packed BCD result.
- cout  output  1  decimal carry out of the top digit. For sub: 1 means no borrow (a≥b).
- err  output  1  at least one captured digit of a or b was > 9.

Behaviour:
- Reset: the asynchronous reset (nrst low) clears all state immediately.
  - busy=0, done=0, o=0, cout=0, err=0.
  - FSM goes to IDLE; index, carry and all operand/shift registers are cleared.
- FSM state IDLE:
  - An edge with start=1 captures a, b and sub, sets carry=sub and index=0, and sets busy=1.
  - It also computes err from all digits of the captured a and b, and moves to RUN.
- FSM state RUN: each edge processes digit[index].
  - bc = sub ? (4'd9 - b_digit) mod 16 : b_digit.
  - z = a_digit + bc + carry, computed in 5 bits.
  - Correction condition: k = z[4] | (z[3]&z[2]) | (z[3]&z[1]).
  - Sum digit = (z[3:0] + (k ? 6 : 0)) mod 16.
  - Next carry = k.
  - The sum digit is stored in position index of the internal shift/result register, and index increments.
- Completion: on the edge that processes digit DIGITS-1:
  - o is loaded with the full result and cout with the final carry.
  - done<=1 for exactly one cycle, busy<=0, and the FSM returns to IDLE.
- Latency:
  - start is accepted at edge 0; done is high in the cycle after edge DIGITS.
  - Throughput is one operation per DIGITS+1 cycles.
  - A start asserted in the done cycle is accepted (back-to-back operation).
- Output stability: o, cout and err change only at completion and hold until the next completion or reset. They do not show intermediate digits while busy.
- start while busy=1: ignored, with no effect on the current operation. a, b and sub may change freely while busy.
- Subtraction results are ten's complement, unsigned:
  - a≥b gives o=a-b, cout=1.
  - a<b gives o=10^DIGITS-(b-a), cout=0.
- Addition overflow: o=(a+b) mod 10^DIGITS, cout=1.
- Invalid digits (> 9):
  - They are processed by the same formula; the value of o is unspecified but deterministic.
  - err=1 is latched at completion and cleared at the next completion with valid digits.
- Reset during RUN: abort at once with all outputs zero; no done pulse is produced.
- DIGITS=1: a single RUN edge; done is high in the cycle after edge 1.

Test Plan:
- DIGITS=4, add 1234+5678, start pulse → busy high for 4 cycles, then done pulse with o=6912, cout=0, err=0.
- Add 9999+0001 → o=0000, cout=1; carry propagates through all four digits.
- sub=1: 5000-1234 → o=3766, cout=1; then 0001-0002 → o=9999, cout=0.
- Handshake: start held high through the whole operation → exactly one result; a second start asserted in the done cycle → next result exactly 5 cycles later; operands changed while busy → result uses the captured values.
- Invalid digit: a=0x12A4, b=0x0001 → err=1 at done; a following valid operation clears err.
- nrst pulsed low during digit 2 → outputs 0 immediately, no done pulse, busy=0; the next start completes normally. Also check DIGITS=1 and DIGITS=8 with random BCD operands against a decimal model.
